// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with pending-write scoreboard and RAW stall
// Optional macro REGFILE_BYPASS_EN: forward the retiring writeback value and busy release to decode.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] sel_rd_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [ADDR_W-1:0] sel_rs1_i,
  input  logic [ADDR_W-1:0] sel_rs2_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_rd_i,
  input  logic              flush_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              stall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [CNT_W-1:0] cnt  [NUM_REGS];

  logic             wr_en;
  logic             dec;
  logic             inc;
  logic             issue_full;
  logic             rs1_pend;
  logic             rs2_pend;
  logic [CNT_W-1:0] cnt_rd;
  logic [CNT_W-1:0] cnt_rs1;
  logic [CNT_W-1:0] cnt_rs2;
  logic [CNT_W-1:0] cnt_issue;

  assign cnt_rd    = cnt[sel_rd_i];
  assign cnt_rs1   = cnt[sel_rs1_i];
  assign cnt_rs2   = cnt[sel_rs2_i];
  assign cnt_issue = cnt[issue_rd_i];

  // A write to a register with nothing outstanding still updates data but never underflows the count.
  assign wr_en = we_i && (sel_rd_i != '0);
  assign dec   = wr_en && (cnt_rd != '0);

  assign rs1_pend = (sel_rs1_i != '0) && (cnt_rs1 != '0);
  assign rs2_pend = (sel_rs2_i != '0) && (cnt_rs2 != '0);

`ifdef REGFILE_BYPASS_EN
  assign rs1_busy_o = rs1_pend && !(dec && (sel_rd_i == sel_rs1_i) && (cnt_rs1 == CNT_ONE));
  assign rs2_busy_o = rs2_pend && !(dec && (sel_rd_i == sel_rs2_i) && (cnt_rs2 == CNT_ONE));
  assign rs1_data_o = (sel_rs1_i == '0) ? '0 :
                      (wr_en && (sel_rd_i == sel_rs1_i)) ? data_i : regs[sel_rs1_i];
  assign rs2_data_o = (sel_rs2_i == '0) ? '0 :
                      (wr_en && (sel_rd_i == sel_rs2_i)) ? data_i : regs[sel_rs2_i];
`else
  assign rs1_busy_o = rs1_pend;
  assign rs2_busy_o = rs2_pend;
  assign rs1_data_o = (sel_rs1_i == '0) ? '0 : regs[sel_rs1_i];
  assign rs2_data_o = (sel_rs2_i == '0) ? '0 : regs[sel_rs2_i];
`endif

  // A saturated destination may still issue if the same register retires one write this cycle.
  assign issue_full = issue_valid_i && (issue_rd_i != '0) && (cnt_issue == CNT_MAX) &&
                      !(dec && (sel_rd_i == issue_rd_i));
  assign stall_o    = rs1_busy_o || rs2_busy_o || issue_full;
  assign inc        = issue_valid_i && !stall_o && (issue_rd_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (wr_en) begin
        regs[sel_rd_i] <= data_i;
      end
      for (int i = 1; i < NUM_REGS; i++) begin
        if (flush_i) begin
          cnt[i] <= '0;
        end else if (inc && (issue_rd_i == ADDR_W'(i)) &&
                     !(dec && (sel_rd_i == ADDR_W'(i)))) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec && (sel_rd_i == ADDR_W'(i)) &&
                     !(inc && (issue_rd_i == ADDR_W'(i)))) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed table, reset sequence and random check against a model
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  sel_rd = '0;
  logic [31:0] data = '0;
  logic [4:0]  sel_rs1 = '0;
  logic [4:0]  sel_rs2 = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        iv = 1'b0;
  logic [4:0]  ird = '0;
  logic        flush = 1'b0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .we_i(we), .sel_rd_i(sel_rd), .data_i(data),
    .sel_rs1_i(sel_rs1), .sel_rs2_i(sel_rs2), .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .issue_valid_i(iv), .issue_rd_i(ird), .flush_i(flush),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy), .stall_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [4:0] rd; logic [31:0] wd; logic [4:0] rs1; logic [4:0] rs2;
    logic iv; logic [4:0] ird; logic fl;
    logic [31:0] d1; logic [31:0] d2; logic b1; logic b2; logic st;
  } vec_t;

  vec_t        vq[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mregs [32];
  int          mcnt  [32];

  function automatic vec_t mk(logic w, logic [4:0] r, logic [31:0] wd, logic [4:0] a, logic [4:0] b,
                              logic i, logic [4:0] ir, logic f, logic [31:0] d1, logic [31:0] d2,
                              logic b1, logic b2, logic st);
    vec_t v;
    v.we = w; v.rd = r; v.wd = wd; v.rs1 = a; v.rs2 = b; v.iv = i; v.ird = ir; v.fl = f;
    v.d1 = d1; v.d2 = d2; v.b1 = b1; v.b2 = b2; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    we = v.we; sel_rd = v.rd; data = v.wd; sel_rs1 = v.rs1; sel_rs2 = v.rs2;
    iv = v.iv; ird = v.ird; flush = v.fl;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mcnt[i]  = 0;
    end
  endfunction

  // Reference rules evaluated on the bench's own register image and outstanding-write counts.
  function automatic logic m_busy(logic [4:0] s);
    if (s == 0 || mcnt[s] == 0) return 1'b0;
    if (BYP && we && sel_rd == s && mcnt[s] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_data(logic [4:0] s);
    if (s == 0) return '0;
    if (BYP && we && sel_rd == s) return data;
    return mregs[s];
  endfunction

  function automatic logic m_stall();
    return m_busy(sel_rs1) | m_busy(sel_rs2) |
           (iv && ird != 0 && mcnt[ird] == MAXC && !(we && sel_rd == ird));
  endfunction

  function automatic void model_commit();
    logic st;
    logic d;
    st = m_stall();
    d  = we && sel_rd != 0 && mcnt[sel_rd] > 0;
    if (flush) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (iv && !st && ird != 0) mcnt[ird]++;
      if (d) mcnt[sel_rd]--;
    end
    if (we && sel_rd != 0) mregs[sel_rd] = data;
  endfunction

  task automatic model_check(input string tag);
    chk({tag, " rs1_data"}, rs1_data, m_data(sel_rs1));
    chk({tag, " rs2_data"}, rs2_data, m_data(sel_rs2));
    chk({tag, " rs1_busy"}, {31'd0, rs1_busy}, {31'd0, m_busy(sel_rs1)});
    chk({tag, " rs2_busy"}, {31'd0, rs2_busy}, {31'd0, m_busy(sel_rs2)});
    chk({tag, " stall"}, {31'd0, stall}, {31'd0, m_stall()});
  endtask

  initial begin
    vec_t v;
    vec_t idle;
    model_clear();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    vq.push_back(mk(0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            5, 0,  0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 32'h12345678, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 7, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            7, 0,  0, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0,            7, 0,  0, 0, 0, 0, 0, 1, 0, 1));
    vq.push_back(mk(1, 7, 32'hA5A5A5A5, 7, 0,  0, 0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, 0, !BYP, 0, !BYP));
    vq.push_back(mk(0, 0, 0,            7, 0,  0, 0, 0, 32'hA5A5A5A5, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 3, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 3, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 3, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 3, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 3, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 3, 32'h33,       0, 0,  1, 3, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 3, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0,            3, 0,  0, 0, 0, 32'h33, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 9, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 10, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            9, 10, 0, 0, 1, 0, 0, 1, 1, 1));
    vq.push_back(mk(0, 0, 0,            9, 10, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            3, 0,  0, 0, 0, 32'h33, 0, 0, 0, 0));
    vq.push_back(mk(1, 9, 32'h99,       0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            0, 0,  1, 9, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,            9, 0,  0, 0, 0, 32'h99, 0, 1, 0, 1));
    vq.push_back(mk(1, 9, 32'h9A,       0, 0,  0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #2;
      chk($sformatf("row%0d rs1_data", i), rs1_data, vq[i].d1);
      chk($sformatf("row%0d rs2_data", i), rs2_data, vq[i].d2);
      chk($sformatf("row%0d rs1_busy", i), {31'd0, rs1_busy}, {31'd0, vq[i].b1});
      chk($sformatf("row%0d rs2_busy", i), {31'd0, rs2_busy}, {31'd0, vq[i].b2});
      chk($sformatf("row%0d stall", i), {31'd0, stall}, {31'd0, vq[i].st});
      model_commit();
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a cycle while x4 is busy.
    drive(mk(1, 4, 32'h55, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0));
    #2;
    model_commit();
    @(posedge clk);
    #1;
    v = idle; v.rs1 = 4;
    drive(v);
    #2;
    chk("pre_reset rs1_busy", {31'd0, rs1_busy}, 32'd1);
    chk("pre_reset rs1_data", rs1_data, 32'h55);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("async_reset stall", {31'd0, stall}, 32'd0);
    chk("async_reset rs1_data", rs1_data, 32'h0);
    #1 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    #2;
    chk("post_reset rs1_data", rs1_data, 32'h0);
    chk("post_reset rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("post_reset stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      v = idle;
      v.we  = ($urandom_range(0, 1) == 1);
      v.rd  = 5'($urandom_range(0, 7));
      v.wd  = $urandom;
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.iv  = ($urandom_range(0, 9) < 6);
      v.ird = 5'($urandom_range(0, 7));
      v.fl  = ($urandom_range(0, 39) == 0);
      drive(v);
      #2;
      model_check($sformatf("rand%0d", n));
      model_commit();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file at the receiving end of the writeback stage's write port (`sel_rd`/`we`/`data`).
- Provides two combinational read ports to decode.
- Contains a per-register pending-write scoreboard. Decode marks a destination busy at issue; writeback clears it on retirement.
- Drives a RAW-hazard stall to the front end.

Parameters:
- NUM_REGS, 32, number of architectural registers (x0 included)
- XLEN, 32, register data width
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
- CNT_W, 2, width of per-register in-flight write counter (max 2^CNT_W-1 outstanding writes per register)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- we_i  in  1  write enable from writeback
- sel_rd_i  in  ADDR_W  write register index from writeback
- data_i  in  XLEN  write data from writeback
- sel_rs1_i  in  ADDR_W  read port 1 index
- sel_rs2_i  in  ADDR_W  read port 2 index
- rs1_data_o  out  XLEN  read port 1 data (combinational)
- rs2_data_o  out  XLEN  read port 2 data (combinational)
- issue_valid_i  in  1  decode issuing an instruction that writes a register
- issue_rd_i  in  ADDR_W  destination of issuing instruction
- flush_i  in  1  pipeline flush; discards all pending-write state
- rs1_busy_o  out  1  rs1 has an unresolved pending write
- rs2_busy_o  out  1  rs2 has an unresolved pending write
- stall_o  out  1  decode must hold this cycle

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- On reset:
  - All registers clear to 0.
  - All counters clear to 0.
  - rs*_busy_o=0 and stall_o=0 (combinational from cleared state).
  - Reset mid-operation discards all pending state immediately.
- Write:
  - At posedge, if we_i=1 and sel_rd_i!=0, regs[sel_rd_i] <= data_i.
  - Writes to x0 are dropped.
  - we_i may be held permanently high by writeback; index 0 makes it a no-op.
- Read:
  - Combinational. sel_rsN_i==0 returns 0.
  - Otherwise returns regs[sel_rsN_i], subject to the bypass rule under Optional Feature.
- Scoreboard, one CNT_W-bit counter per register (index 0 counter tied to 0):
  - inc = issue_valid_i && !stall_o && issue_rd_i!=0.
  - dec = we_i && sel_rd_i!=0 && cnt[sel_rd_i]!=0. A write to a register with count 0 leaves the count at 0; no underflow.
  - Same register gets inc and dec in the same cycle: count unchanged.
  - Different registers: each updates independently.
  - flush_i=1: all counters cleared at the next edge. flush_i has priority over a simultaneous inc/dec.
- Busy:
  - rsN_busy_o = (sel_rsN_i!=0) && cnt[sel_rsN_i]!=0, except when it is resolved this cycle (see Optional Feature).
- Stall:
  - stall_o = rs1_busy_o | rs2_busy_o | (issue_valid_i && issue_rd_i!=0 && cnt[issue_rd_i]==max && !dec on that register).
  - Issue is ignored (no inc) while stall_o=1.
- No clocked outputs; all outputs are combinational from registered state plus the current inputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined (bypass on):
  - If we_i && sel_rd_i!=0 && sel_rd_i==sel_rsN_i, then rsN_data_o = data_i (write-through).
  - rsN_busy_o is suppressed when cnt[sel_rsN_i]==1 and that same write retires this cycle.
- Undefined (bypass off):
  - Reads always return stored regs[].
  - rsN_busy_o remains 1 in the retiring cycle and clears the following cycle.
  - Adds one stall cycle per dependent read.

Test Plan:
- Reset, then write x5=0xDEADBEEF (we_i=1, sel_rd_i=5); next cycle read rs1=5 -> rs1_data_o=0xDEADBEEF, rs1_busy_o=0.
- Write x0=0x12345678; read rs1=0, rs2=0 -> both 0x00000000; no busy, no stall.
- Issue rd=7, then read rs1=7 -> rs1_busy_o=1, stall_o=1 until writeback writes x7=0xA5A5A5A5.
  - With REGFILE_BYPASS_EN: stall drops in the write cycle and rs1_data_o=0xA5A5A5A5 in that cycle.
  - Without REGFILE_BYPASS_EN: stall drops one cycle later.
- Issue rd=3 three times (cnt=3); fourth issue rd=3 -> stall_o=1 and count stays 3. Next, write x3 and issue rd=3 in the same cycle -> count stays 3 and stall_o=0.
- Issue rd=9 and rd=10, assert flush_i for one cycle -> next cycle reading rs1=9, rs2=10 gives both busy=0 and stall_o=0.
- Assert rst_n=0 asynchronously mid-stream with x4 busy and x4=0x55 -> outputs immediately show busy=0; after release, read x4 -> 0.
